pipeline_skid_deliver: RTL and testbench

//   Elastic pipeline register between two core stages, replacing the stall-driven

---
 rtl/pipeline_skid_deliver.sv | 152 +++++++++++++++
 tb/tb_pipeline_skid_deliver.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_skid_deliver.sv
// pipeline_skid_deliver
// Elastic register slice between two core stages. A main entry plus an
// optional skid entry let the upstream in_ready come straight from a flop
// while still sustaining one transfer per cycle. Includes pipeline flush,
// bubble value on the output and a saturating back-pressure counter.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready
// are both 1 on that side (in_fire = in_valid & in_ready,
// out_fire = out_valid & out_ready). A producer holding valid=1 keeps its
// data stable until the transfer; out_data never changes while out_valid=1
// and out_ready=0.
//
// dbg_state exposes the occupancy FSM: 2'b00 empty, 2'b01 main only,
// 2'b11 main and skid.

module pipeline_skid_deliver #(
   parameter int unsigned          kWidth    = 32,
   parameter logic [kWidth-1:0]    kRstVal   = '0,
   parameter bit                   kSkidEn   = 1'b1,
   parameter int unsigned          kCntWidth = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [kWidth-1:0]    in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [kWidth-1:0]    out_data,
   output logic [kCntWidth-1:0] stall_cnt,
   output logic [1:0]           dbg_state
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_BUSY  = 2'b01,
      ST_FULL  = 2'b11
   } state_e;

   localparam logic [kCntWidth-1:0] kCntMax = '1;

   state_e              state_q, state_d;
   logic [kWidth-1:0]   main_q, main_d;
   logic [kWidth-1:0]   skid_q, skid_d;
   logic [kCntWidth-1:0] stall_cnt_q, stall_cnt_d;

   logic main_v;
   logic skid_v;
   logic in_fire;
   logic out_fire;

   // Occupancy flags are direct decodes of the state flops.
   assign main_v = state_q[0];
   assign skid_v = state_q[1];

   // Upstream ready: registered (skid present) or pass-through of downstream ready.
   always_comb begin
      if (kSkidEn) begin
         in_ready = ~skid_v;
      end else begin
         in_ready = ~main_v | out_ready;
      end
   end

   assign in_fire   = in_valid & in_ready;
   assign out_fire  = main_v & out_ready;

   assign out_valid = main_v;
   // main_q is already cleared to the bubble value when empty; gate anyway so
   // the bubble value is guaranteed on the bus.
   assign out_data  = main_v ? main_q : kRstVal;
   assign stall_cnt = stall_cnt_q;
   assign dbg_state = state_q;

   // Next-state and datapath selection; flush overrides any handshake.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = ST_EMPTY;
         main_d  = kRstVal;
         skid_d  = kRstVal;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  state_d = ST_BUSY;
                  main_d  = in_data;
               end
            end
            ST_BUSY: begin
               if (in_fire && out_fire) begin
                  main_d = in_data;
               end else if (in_fire) begin
                  // Only reachable with the skid entry enabled: without it
                  // in_ready in this state equals out_ready.
                  state_d = ST_FULL;
                  skid_d  = in_data;
               end else if (out_fire) begin
                  state_d = ST_EMPTY;
                  main_d  = kRstVal;
               end
            end
            ST_FULL: begin
               if (out_fire) begin
                  state_d = ST_BUSY;
                  main_d  = skid_q;
                  skid_d  = kRstVal;
               end
            end
            default: begin
               state_d = ST_EMPTY;
               main_d  = kRstVal;
               skid_d  = kRstVal;
            end
         endcase
      end
   end

   // Saturating count of cycles where output is presented but not taken.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (main_v && !out_ready && (stall_cnt_q != kCntMax)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   // State and payload registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         main_q  <= kRstVal;
         skid_q  <= kRstVal;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   // Back-pressure counter register; only reset clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_pipeline_skid_deliver.sv
// Bench for pipeline_skid_deliver. Three instances share one clock:
//   0: skid buffer, 16-bit counter (reset, streaming, back-pressure, flush)
//   1: skid buffer, 3-bit counter (saturation)
//   2: no skid, combinational in_ready
// A FIFO-level model tracks each instance and is compared every cycle;
// directed steps add hand-computed literal checks.

module tb_pipeline_skid_deliver;

   logic        clk;
   logic        rst;
   logic        fl   [3];
   logic        iv   [3];
   logic [31:0] id   [3];
   logic        ordy [3];

   logic        ir   [3];
   logic        ov   [3];
   logic [31:0] od   [3];
   logic [1:0]  dbg  [3];
   logic [15:0] st_a;
   logic [2:0]  st_b;
   logic [15:0] st_c;

   int checks   = 0;
   int failures = 0;

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   pipeline_skid_deliver #(.kWidth(32), .kRstVal(32'h0), .kSkidEn(1'b1), .kCntWidth(16)) u_a (
      .clk(clk), .rst(rst), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir[0]),
      .in_data(id[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
      .stall_cnt(st_a), .dbg_state(dbg[0]));

   pipeline_skid_deliver #(.kWidth(32), .kRstVal(32'h0), .kSkidEn(1'b1), .kCntWidth(3)) u_b (
      .clk(clk), .rst(rst), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir[1]),
      .in_data(id[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
      .stall_cnt(st_b), .dbg_state(dbg[1]));

   pipeline_skid_deliver #(.kWidth(32), .kRstVal(32'h0), .kSkidEn(1'b0), .kCntWidth(16)) u_c (
      .clk(clk), .rst(rst), .flush(fl[2]), .in_valid(iv[2]), .in_ready(ir[2]),
      .in_data(id[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]),
      .stall_cnt(st_c), .dbg_state(dbg[2]));

   // ---------------- model ----------------
   int          m_cnt   [3];
   logic [31:0] m_data  [3][2];
   int          m_stall [3];
   bit          m_live = 1'b0;

   function automatic int stall_max(input int i);
      return (i == 1) ? 7 : 65535;
   endfunction

   function automatic bit m_in_ready(input int i);
      if (i == 2) return (m_cnt[i] == 0) || ordy[i];
      return m_cnt[i] < 2;
   endfunction

   function automatic logic [1:0] m_dbg(input int i);
      case (m_cnt[i])
         0:       return 2'b00;
         1:       return 2'b01;
         default: return 2'b11;
      endcase
   endfunction

   initial begin
      for (int i = 0; i < 3; i++) begin
         m_cnt[i]   = 0;
         m_stall[i] = 0;
      end
   end

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         bit ifire;
         bit ofire;
         ifire = iv[i] && m_in_ready(i);
         ofire = (m_cnt[i] > 0) && ordy[i];
         if (rst) begin
            m_cnt[i]   = 0;
            m_stall[i] = 0;
         end else begin
            if ((m_cnt[i] > 0) && !ordy[i] && (m_stall[i] < stall_max(i)))
               m_stall[i] = m_stall[i] + 1;
            if (fl[i]) begin
               m_cnt[i] = 0;
            end else begin
               if (ofire) begin
                  m_data[i][0] = m_data[i][1];
                  m_cnt[i]     = m_cnt[i] - 1;
               end
               if (ifire && m_cnt[i] < 2) begin
                  m_data[i][m_cnt[i]] = id[i];
                  m_cnt[i]            = m_cnt[i] + 1;
               end
            end
         end
      end
      m_live = 1'b1;
   end

   // ---------------- scoreboard ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (m_live) begin
         for (int i = 0; i < 3; i++) begin
            logic [31:0] e_data;
            logic [31:0] a_st;
            e_data = (m_cnt[i] > 0) ? m_data[i][0] : 32'h0;
            a_st   = (i == 0) ? {16'd0, st_a} : (i == 1) ? {29'd0, st_b} : {16'd0, st_c};
            chk($sformatf("m%0d_out_valid", i), {31'd0, ov[i]}, {31'd0, (m_cnt[i] > 0)});
            chk($sformatf("m%0d_out_data", i), od[i], e_data);
            chk($sformatf("m%0d_in_ready", i), {31'd0, ir[i]}, {31'd0, m_in_ready(i)});
            chk($sformatf("m%0d_stall_cnt", i), a_st, m_stall[i]);
            chk($sformatf("m%0d_dbg_state", i), {30'd0, dbg[i]}, {30'd0, m_dbg(i)});
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         fl[i] = 1'b0; iv[i] = 1'b0; id[i] = 32'h0; ordy[i] = 1'b0;
      end

      // Reset with garbage on the inputs
      iv[0] = 1'b1; id[0] = 32'hAA; ordy[0] = 1'b1;
      cyc(); cyc();
      chk("rst_out_valid", {31'd0, ov[0]}, 32'd0);
      chk("rst_out_data", od[0], 32'h0);
      chk("rst_stall", {16'd0, st_a}, 32'd0);
      chk("rst_in_ready", {31'd0, ir[0]}, 32'd1);
      rst = 1'b0; iv[0] = 1'b0;

      // Streaming 1..4
      ordy[0] = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         iv[0] = 1'b1; id[0] = k;
         cyc();
         chk("stream_valid", {31'd0, ov[0]}, 32'd1);
         chk("stream_data", od[0], k);
         chk("stream_in_ready", {31'd0, ir[0]}, 32'd1);
      end
      iv[0] = 1'b0;
      cyc();
      chk("stream_drained", {31'd0, ov[0]}, 32'd0);

      // Back-pressure 0x10, 0x11
      ordy[0] = 1'b0; iv[0] = 1'b1; id[0] = 32'h10;
      cyc();
      chk("bp_first_data", od[0], 32'h10);
      chk("bp_first_ready", {31'd0, ir[0]}, 32'd1);
      id[0] = 32'h11;
      cyc();
      chk("bp_full_ready", {31'd0, ir[0]}, 32'd0);
      chk("bp_full_data", od[0], 32'h10);
      chk("bp_stall1", {16'd0, st_a}, 32'd1);
      iv[0] = 1'b0;
      cyc();
      chk("bp_stall2", {16'd0, st_a}, 32'd2);
      chk("bp_hold_data", od[0], 32'h10);
      cyc();
      chk("bp_stall3", {16'd0, st_a}, 32'd3);
      ordy[0] = 1'b1;
      cyc();
      chk("bp_second_data", od[0], 32'h11);
      chk("bp_ready_back", {31'd0, ir[0]}, 32'd1);
      chk("bp_stall_frozen", {16'd0, st_a}, 32'd3);
      cyc();
      chk("bp_drained", {31'd0, ov[0]}, 32'd0);

      // Flush while full, with a competing input
      ordy[0] = 1'b0; iv[0] = 1'b1; id[0] = 32'h20;
      cyc();
      id[0] = 32'h21;
      cyc();
      chk("fl_full_ready", {31'd0, ir[0]}, 32'd0);
      chk("fl_full_data", od[0], 32'h20);
      fl[0] = 1'b1; id[0] = 32'h22;
      cyc();
      chk("fl_valid", {31'd0, ov[0]}, 32'd0);
      chk("fl_data", od[0], 32'h0);
      chk("fl_ready", {31'd0, ir[0]}, 32'd1);
      chk("fl_stall_kept", {16'd0, st_a}, 32'd5);
      fl[0] = 1'b0; iv[0] = 1'b0; ordy[0] = 1'b1;
      cyc(); cyc();
      chk("fl_no_ghost", {31'd0, ov[0]}, 32'd0);

      // Saturation on the 3-bit counter instance
      ordy[1] = 1'b0; iv[1] = 1'b1; id[1] = 32'h55;
      cyc();
      iv[1] = 1'b0;
      repeat (10) cyc();
      chk("sat_value", {29'd0, st_b}, 32'd7);
      cyc();
      chk("sat_hold", {29'd0, st_b}, 32'd7);
      chk("sat_data", od[1], 32'h55);

      // Single-register variant
      ordy[2] = 1'b0; iv[2] = 1'b1; id[2] = 32'h30;
      cyc();
      iv[2] = 1'b0;
      cyc();
      chk("ns_hold_data", od[2], 32'h30);
      chk("ns_blocked", {31'd0, ir[2]}, 32'd0);
      ordy[2] = 1'b1; iv[2] = 1'b1; id[2] = 32'h31;
      #1;
      chk("ns_comb_ready", {31'd0, ir[2]}, 32'd1);
      cyc();
      chk("ns_next_data", od[2], 32'h31);
      chk("ns_next_valid", {31'd0, ov[2]}, 32'd1);
      iv[2] = 1'b0;
      cyc();
      chk("ns_drained", {31'd0, ov[2]}, 32'd0);

      cyc(); cyc();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
